// File: rtl/egress_frame_monitor.sv
// egress_frame_monitor: re-times the egress byte stream by one stage, checks framing/length/FCS and keeps frame statistics
module egress_frame_monitor #(
    parameter int serialWidth   = 8,
    parameter int minFrameBytes = 64,
    parameter int maxFrameBytes = 1518,
    parameter bit checkCrc      = 1'b1
) (
    input  logic                   popClk,
    input  logic                   rstn,
    input  logic [serialWidth-1:0] inData,
    input  logic                   inPresent,
    input  logic                   inStartOfFrame,
    input  logic                   inEndOfFrame,
    input  logic                   inError,
    input  logic                   clearCounters,
    output logic [serialWidth-1:0] txData,
    output logic                   txValid,
    output logic                   txStartOfFrame,
    output logic                   txEndOfFrame,
    output logic                   txError,
    output logic [31:0]            goodFrameCount,
    output logic [15:0]            badFrameCount,
    output logic [31:0]            byteCount,
    output logic [15:0]            orphanCount
);
    localparam int LW = $clog2(maxFrameBytes + 2);
    localparam logic [LW-1:0] MIN_LEN = LW'(minFrameBytes);
    localparam logic [LW-1:0] MAX_LEN = LW'(maxFrameBytes);
    localparam logic [LW-1:0] SAT_LEN = LW'(maxFrameBytes + 1);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;

    generate
        if (serialWidth != 8) begin : g_width_check
            $error("egress_frame_monitor: serialWidth must be 8");
        end
    endgenerate

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    logic [0:0]             state_q, state_d;
    logic [LW-1:0]          len_q, len_d;
    logic [31:0]            crc_q, crc_d;
    logic                   frame_err_q, frame_err_d;
    logic [serialWidth-1:0] tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_sof_q, tx_sof_d;
    logic                   tx_eof_q, tx_eof_d;
    logic                   tx_err_q, tx_err_d;
    logic [31:0]            good_q, good_d;
    logic [15:0]            bad_q, bad_d;
    logic [31:0]            bytes_q, bytes_d;
    logic [15:0]            orphan_q, orphan_d;

    logic          in_frame, accept, abort, orphan, eof, frame_bad, frame_good;
    logic [LW-1:0] len_cur;
    logic [31:0]   crc_cur;
    logic          err_cur;
    logic [1:0]    bad_inc;
    logic [16:0]   bad_sum;

    always_comb begin
        in_frame   = state_q == IN_FRAME;
        accept     = inPresent && (in_frame || inStartOfFrame);
        abort      = inPresent && in_frame && inStartOfFrame;
        orphan     = inPresent && !in_frame && !inStartOfFrame;
        eof        = accept && inEndOfFrame;
        // A SOF beat always restarts the per-frame state, whether from IDLE or as an abort.
        crc_cur    = crc_next(inStartOfFrame ? CRC_INIT : crc_q, inData);
        len_cur    = inStartOfFrame ? LW'(1) : (len_q == SAT_LEN ? len_q : len_q + 1'b1);
        err_cur    = (!inStartOfFrame && frame_err_q) || inError;
        frame_bad  = err_cur || len_cur < MIN_LEN || len_cur > MAX_LEN || (checkCrc && crc_cur != CRC_RESIDUE);
        frame_good = eof && !frame_bad;
        bad_inc    = {1'b0, abort} + {1'b0, eof && frame_bad};
        bad_sum    = {1'b0, bad_q} + 17'(bad_inc);
        state_d     = accept ? (inEndOfFrame ? IDLE : IN_FRAME) : state_q;
        len_d       = accept ? len_cur : len_q;
        crc_d       = accept ? crc_cur : crc_q;
        frame_err_d = accept ? err_cur : frame_err_q;
        tx_valid_d  = accept;
        tx_data_d   = accept ? inData : '0;
        tx_sof_d    = accept && inStartOfFrame;
        tx_eof_d    = eof;
        tx_err_d    = accept && (inError || abort || (inEndOfFrame && frame_bad));
        good_d      = clearCounters ? '0 : good_q + 32'(frame_good);
        bad_d       = clearCounters ? '0 : (bad_sum[16] ? 16'hFFFF : bad_sum[15:0]);
        bytes_d     = clearCounters ? '0 : bytes_q + 32'(accept);
        orphan_d    = clearCounters ? '0 : ((orphan && orphan_q != 16'hFFFF) ? orphan_q + 16'd1 : orphan_q);
    end

    always_ff @(posedge popClk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            crc_q       <= CRC_INIT;
            frame_err_q <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_sof_q    <= 1'b0;
            tx_eof_q    <= 1'b0;
            tx_err_q    <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            bytes_q     <= '0;
            orphan_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            frame_err_q <= frame_err_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_sof_q    <= tx_sof_d;
            tx_eof_q    <= tx_eof_d;
            tx_err_q    <= tx_err_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            bytes_q     <= bytes_d;
            orphan_q    <= orphan_d;
        end
    end

    assign txData         = tx_data_q;
    assign txValid        = tx_valid_q;
    assign txStartOfFrame = tx_sof_q;
    assign txEndOfFrame   = tx_eof_q;
    assign txError        = tx_err_q;
    assign goodFrameCount = good_q;
    assign badFrameCount  = bad_q;
    assign byteCount      = bytes_q;
    assign orphanCount    = orphan_q;
endmodule

// File: tb/tb_egress_frame_monitor.sv
// tb_egress_frame_monitor: directed scoreboard bench driving a min-length-4 instance and a default instance in lockstep
module tb_egress_frame_monitor;
    logic        popClk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  inData = '0;
    logic        inPresent = 1'b0, inStartOfFrame = 1'b0, inEndOfFrame = 1'b0, inError = 1'b0, clearCounters = 1'b0;
    logic [7:0]  tx_data, tx_data4;
    logic        tx_valid, tx_sof, tx_eof, tx_err, tx_valid4, tx_sof4, tx_eof4, tx_err4;
    logic [31:0] good, good4, bytes, bytes4;
    logic [15:0] bad, bad4, orph, orph4;
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       s, e, x, x4;
    } rec_t;
    rec_t q[$];
    logic [7:0] fb [0:1599];

    always #5 popClk = ~popClk;

    egress_frame_monitor #(.minFrameBytes(4)) dut4 (
        .popClk(popClk), .rstn(rstn), .inData(inData), .inPresent(inPresent),
        .inStartOfFrame(inStartOfFrame), .inEndOfFrame(inEndOfFrame), .inError(inError),
        .clearCounters(clearCounters), .txData(tx_data4), .txValid(tx_valid4),
        .txStartOfFrame(tx_sof4), .txEndOfFrame(tx_eof4), .txError(tx_err4),
        .goodFrameCount(good4), .badFrameCount(bad4), .byteCount(bytes4), .orphanCount(orph4)
    );

    egress_frame_monitor dut (
        .popClk(popClk), .rstn(rstn), .inData(inData), .inPresent(inPresent),
        .inStartOfFrame(inStartOfFrame), .inEndOfFrame(inEndOfFrame), .inError(inError),
        .clearCounters(clearCounters), .txData(tx_data), .txValid(tx_valid),
        .txStartOfFrame(tx_sof), .txEndOfFrame(tx_eof), .txError(tx_err),
        .goodFrameCount(good), .badFrameCount(bad), .byteCount(bytes), .orphanCount(orph)
    );

    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else c = c >> 1;
        end
        return c;
    endfunction

    function automatic void make_frame(input int n, input int seed);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            fb[i] = 8'(i * 13 + seed);
            c = crc_ref(c, fb[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fb[n - 4 + k] = c[8*k +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic p, s, e, er, clr, input logic v, xe, xe4);
        rec_t r;
        @(negedge popClk);
        inData = d; inPresent = p; inStartOfFrame = s; inEndOfFrame = e; inError = er; clearCounters = clr;
        q.push_back('{v: v, d: v ? d : 8'h00, s: v & s, e: v & e, x: xe, x4: xe4});
        @(posedge popClk);
        #2;
        r = q.pop_front();
        chk("txValid", tx_valid, r.v);
        chk("txData", tx_data, r.d);
        chk("txStartOfFrame", tx_sof, r.s);
        chk("txEndOfFrame", tx_eof, r.e);
        chk("txError", tx_err, r.x);
        chk("txValid4", tx_valid4, r.v);
        chk("txData4", tx_data4, r.d);
        chk("txStartOfFrame4", tx_sof4, r.s);
        chk("txEndOfFrame4", tx_eof4, r.e);
        chk("txError4", tx_err4, r.x4);
    endtask

    task automatic idle(input logic clr);
        beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, clr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input bit eof_on, input int err_at, input bit fbad, input bit fbad4,
                              input bit abort_first, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            logic s, e, er;
            s = i == 0;
            e = eof_on && i == n - 1;
            er = i == err_at;
            beat(fb[i], 1'b1, s, e, er, clr_last && e, 1'b1,
                 er | (s & abort_first) | (e & fbad), er | (s & abort_first) | (e & fbad4));
        end
    endtask

    task automatic check_cnt(input string tag, input int g, b, by, o, g4, b4, by4, o4);
        chk({tag, " good"}, good, g);
        chk({tag, " bad"}, bad, b);
        chk({tag, " bytes"}, bytes, by);
        chk({tag, " orphan"}, orph, o);
        chk({tag, " good4"}, good4, g4);
        chk({tag, " bad4"}, bad4, b4);
        chk({tag, " bytes4"}, bytes4, by4);
        chk({tag, " orphan4"}, orph4, o4);
    endtask

    initial begin
        logic [103:0] tv;
        // reset state
        idle(1'b0);
        idle(1'b0);
        check_cnt("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        idle(1'b0);
        // "123456789" with its known FCS: good only where 13 bytes is long enough
        tv = {"123456789", 8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) fb[i] = tv[8*(12-i) +: 8];
        send_frame(13, 1, -1, 1, 0, 0, 0);
        idle(1'b0);
        check_cnt("crc_vec", 0, 1, 13, 0, 1, 0, 13, 0);
        idle(1'b1);
        // corrupted payload byte
        fb[4] = 8'h36;
        send_frame(13, 1, -1, 1, 1, 0, 0);
        idle(1'b0);
        check_cnt("crc_bad", 0, 1, 13, 0, 0, 1, 13, 0);
        idle(1'b1);
        // length boundaries, back-to-back frames
        make_frame(63, 3);
        send_frame(63, 1, -1, 1, 0, 0, 0);
        make_frame(1519, 7);
        send_frame(1519, 1, -1, 1, 1, 0, 0);
        make_frame(64, 11);
        send_frame(64, 1, -1, 0, 0, 0, 0);
        idle(1'b0);
        check_cnt("length", 1, 2, 1646, 0, 2, 1, 1646, 0);
        idle(1'b1);
        // abort by a new SOF
        make_frame(64, 21);
        send_frame(10, 0, -1, 0, 0, 0, 0);
        send_frame(64, 1, -1, 0, 0, 1, 0);
        idle(1'b0);
        check_cnt("abort", 1, 1, 74, 0, 1, 1, 74, 0);
        idle(1'b1);
        // orphans, then clear coincident with a good EOF
        for (int i = 0; i < 3; i++) beat(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check_cnt("orphan", 0, 0, 0, 3, 0, 0, 0, 3);
        send_frame(64, 1, -1, 0, 0, 0, 1);
        idle(1'b0);
        check_cnt("clear", 0, 0, 0, 0, 0, 0, 0, 0);
        // abort coinciding with a bad single-beat frame counts twice
        send_frame(5, 0, -1, 0, 0, 0, 0);
        beat(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        check_cnt("abort_single", 0, 2, 6, 0, 0, 2, 6, 0);
        idle(1'b1);
        // upstream error mid-frame
        make_frame(64, 33);
        send_frame(64, 1, 30, 1, 1, 0, 0);
        idle(1'b0);
        check_cnt("in_error", 0, 1, 64, 0, 0, 1, 64, 0);
        // reset mid-frame at byte 20
        make_frame(64, 45);
        send_frame(20, 0, -1, 0, 0, 0, 0);
        rstn = 1'b0;
        idle(1'b0);
        idle(1'b0);
        check_cnt("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        send_frame(64, 1, -1, 0, 0, 0, 0);
        idle(1'b0);
        check_cnt("post_reset", 1, 0, 64, 0, 1, 0, 64, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
